// File: rtl/nios_system_tec2_multi_timer_if.sv
// Register-bus bundle for the multi-channel timer: word-addressed access plus the combined interrupt.
interface nios_system_tec2_multi_timer_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/nios_system_tec2_multi_timer.sv
// Multi-channel down-counting interval timer with status/control/period/snapshot registers per channel.
// Optional MULTI_TIMER_CASCADE_EN adds control bit 4 (CAS): channel n steps only on channel n-1 timeouts.
module nios_system_tec2_multi_timer #(
    parameter int          NUM_CH         = 2,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] RELOAD_DEFAULT = 32'd49999
) (
    input  logic clk,
    input  logic reset,
    nios_system_tec2_multi_timer_if.slave bus
);
    localparam logic [CNT_W-1:0] RELOAD_VAL = RELOAD_DEFAULT[CNT_W-1:0];

    logic        wr_en;
    logic [1:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] rd_val [4];
    logic [3:0]  irq_ch;
    // tmo[i+1] is channel i's timeout event; tmo[0] feeds the cascade input of channel 0
    logic [4:0]  tmo;
    logic        unused_sink;

    assign wr_en       = bus.chipselect & ~bus.write_n;
    assign ch_sel      = bus.address[3:2];
    assign reg_sel     = bus.address[1:0];
    assign tmo[0]      = 1'b0;
    assign unused_sink = ^{bus.writedata, tmo};

    for (genvar i = 0; i < 4; i++) begin : g_ch
        if (i < NUM_CH) begin : g_live
            logic [CNT_W-1:0] counter;
            logic [CNT_W-1:0] period;
            logic [CNT_W-1:0] snapshot;
            logic             run;
            logic             to;
            logic             cont;
            logic             ito;
            logic             cas;
            logic             zero_q;
            logic             reload_pend;
            logic             sel;
            logic             zero;
            logic             step;
            logic [31:0]      rd_local;

            assign sel       = wr_en && (ch_sel == 2'(i));
            assign zero      = (counter == '0);
            assign step      = run & (~cas | tmo[i]);
            // zero_q holds the zero flag of the previous step; period 0 times out on every step
            assign tmo[i+1]  = step & zero & (~zero_q | (period == '0));
            assign irq_ch[i] = to & ito;

            always_ff @(posedge clk) begin
                if (reset) begin
                    counter     <= RELOAD_VAL;
                    period      <= RELOAD_VAL;
                    snapshot    <= '0;
                    run         <= 1'b0;
                    to          <= 1'b0;
                    cont        <= 1'b0;
                    ito         <= 1'b0;
                    zero_q      <= 1'b0;
                    reload_pend <= 1'b0;
                end else begin
                    if (reload_pend) begin
                        counter     <= period;
                        reload_pend <= 1'b0;
                        zero_q      <= 1'b0;
                    end else if (step) begin
                        counter <= zero ? period : counter - CNT_W'(1);
                        zero_q  <= zero;
                    end
                    to <= tmo[i+1] | (to & ~(sel && reg_sel == 2'd0));
                    if (tmo[i+1] && !cont) run <= 1'b0;
                    if (sel) begin
                        case (reg_sel)
                            2'd1: begin
                                cont <= bus.writedata[1];
                                ito  <= bus.writedata[0];
                                if (bus.writedata[2])      run <= 1'b1;
                                else if (bus.writedata[3]) run <= 1'b0;
                            end
                            2'd2: begin
                                period      <= bus.writedata[CNT_W-1:0];
                                reload_pend <= 1'b1;
                                run         <= 1'b0;
                            end
                            2'd3: snapshot <= counter;
                            default: ;
                        endcase
                    end
                end
            end

`ifdef MULTI_TIMER_CASCADE_EN
            always_ff @(posedge clk) begin
                if (reset) cas <= 1'b0;
                else if (sel && reg_sel == 2'd1) cas <= (i != 0) && bus.writedata[4];
            end
`else
            assign cas = 1'b0;
`endif

            always_comb begin
                rd_local = '0;
                case (reg_sel)
                    2'd0:    rd_local = {30'd0, run, to};
                    2'd1:    rd_local = {27'd0, cas, 2'b00, cont, ito};
                    2'd2:    rd_local = 32'(period);
                    default: rd_local = 32'(snapshot);
                endcase
            end
            assign rd_val[i] = rd_local;
        end else begin : g_absent
            assign rd_val[i]  = '0;
            assign irq_ch[i]  = 1'b0;
            assign tmo[i+1]   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_val[ch_sel];
    end

    assign bus.irq = |irq_ch;
endmodule

// File: tb/tb_nios_system_tec2_multi_timer.sv
// Bench for nios_system_tec2_multi_timer: register table, timing sequences and a randomized model check.
module tb_nios_system_tec2_multi_timer;
    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam int unsigned RELOAD = 49999;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios_system_tec2_multi_timer_if bus ();

    nios_system_tec2_multi_timer #(
        .NUM_CH(NCH), .CNT_W(CW), .RELOAD_DEFAULT(32'd49999)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [18];

    // behavioural model: a running channel sitting at zero times out that cycle and reloads
    int unsigned m_cnt [4];
    int unsigned m_per [4];
    int unsigned m_snap [4];
    bit m_run [4];
    bit m_to [4];
    bit m_cont [4];
    bit m_ito [4];
    bit m_pend [4];
    logic [31:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_raw(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] d);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = d;
    endtask

    task automatic op(input logic wr, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_raw(wr, ~wr, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_raw(1'b0, 1'b1, 4'h0, 32'd0);
        end
    endtask

    // a bus write is presented throughout reset; reset must win
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_raw(1'b1, 1'b0, 4'h2, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive_raw(1'b0, 1'b1, 4'h0, 32'd0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = RELOAD; m_per[c] = RELOAD; m_snap[c] = 0;
            m_run[c] = 0; m_to[c] = 0; m_cont[c] = 0; m_ito[c] = 0; m_pend[c] = 0;
        end
        m_rd = 32'd0;
    endtask

    function automatic logic m_irq();
        logic v;
        v = 1'b0;
        for (int c = 0; c < NCH; c++) v = v | (m_to[c] & m_ito[c]);
        return v;
    endfunction

    task automatic model_edge(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] d);
        bit wr;
        int c;
        int r;
        logic [31:0] nrd;
        wr  = cs && !wn;
        c   = int'(a[3:2]);
        r   = int'(a[1:0]);
        nrd = 32'd0;
        if (c < NCH) begin
            case (r)
                0: nrd = {30'd0, m_run[c], m_to[c]};
                1: nrd = {30'd0, m_cont[c], m_ito[c]};
                2: nrd = m_per[c];
                default: nrd = m_snap[c];
            endcase
        end
        for (int ch = 0; ch < NCH; ch++) begin
            bit hit;
            bit fire;
            int unsigned pre;
            hit  = wr && (c == ch);
            fire = m_run[ch] && (m_cnt[ch] == 0);
            pre  = m_cnt[ch];
            if (m_pend[ch])     m_cnt[ch] = m_per[ch];
            else if (m_run[ch]) m_cnt[ch] = (pre == 0) ? m_per[ch] : pre - 1;
            m_pend[ch] = 0;
            m_to[ch]   = fire || (m_to[ch] && !(hit && r == 0));
            if (fire && !m_cont[ch]) m_run[ch] = 0;
            if (hit && r == 1) begin
                m_cont[ch] = d[1];
                m_ito[ch]  = d[0];
                if (d[2])      m_run[ch] = 1;
                else if (d[3]) m_run[ch] = 0;
            end
            if (hit && r == 2) begin
                m_per[ch]  = d & 32'h0000_FFFF;
                m_pend[ch] = 1;
                m_run[ch]  = 0;
            end
            if (hit && r == 3) m_snap[ch] = pre;
        end
        m_rd = nrd;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int second;
        drive_raw(1'b0, 1'b1, 4'h0, 32'd0);

        vecs[0]  = '{1'b0, 4'h2, 32'd0,          1'b1, 32'd49999};
        vecs[1]  = '{1'b0, 4'h4, 32'd0,          1'b1, 32'd0};
        vecs[2]  = '{1'b0, 4'h1, 32'd0,          1'b1, 32'd0};
        vecs[3]  = '{1'b0, 4'h3, 32'd0,          1'b1, 32'd0};
        vecs[4]  = '{1'b1, 4'h2, 32'h1234_5678,  1'b0, 32'd0};
        vecs[5]  = '{1'b0, 4'h2, 32'd0,          1'b1, 32'h5678};
        vecs[6]  = '{1'b1, 4'h1, 32'h1B,         1'b0, 32'd0};
        vecs[7]  = '{1'b0, 4'h1, 32'd0,          1'b1, 32'h3};
        vecs[8]  = '{1'b0, 4'h0, 32'd0,          1'b1, 32'd0};
        vecs[9]  = '{1'b1, 4'hE, 32'd5,          1'b0, 32'd0};
        vecs[10] = '{1'b0, 4'hE, 32'd0,          1'b1, 32'd0};
        vecs[11] = '{1'b0, 4'h8, 32'd0,          1'b1, 32'd0};
        vecs[12] = '{1'b1, 4'h5, 32'h3,          1'b0, 32'd0};
        vecs[13] = '{1'b0, 4'h4, 32'd0,          1'b1, 32'd0};
        vecs[14] = '{1'b0, 4'h5, 32'd0,          1'b1, 32'h3};
        vecs[15] = '{1'b0, 4'h6, 32'd0,          1'b1, 32'd49999};
        vecs[16] = '{1'b1, 4'h3, 32'hDEAD,       1'b0, 32'd0};
        vecs[17] = '{1'b0, 4'h3, 32'd0,          1'b1, 32'h5678};

        // register table
        do_reset();
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i > 0 && vecs[i-1].chk) check($sformatf("vec%0d", i - 1), bus.readdata, vecs[i-1].exp);
            check($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, 32'd0);
            drive_raw(vecs[i].wr, ~vecs[i].wr, vecs[i].addr, vecs[i].data);
        end
        @(negedge clk);
        check("vec17", bus.readdata, vecs[17].exp);

        // continuous period 9 with interrupt: timeout every 10 cycles
        do_reset();
        op(1'b1, 4'h2, 32'd9);
        op(1'b1, 4'h1, 32'h7);
        first = 0;
        second = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            drive_raw(1'b0, 1'b1, 4'h0, 32'd0);
            if (bus.irq) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
                drive_raw(1'b1, 1'b0, 4'h0, 32'd0);
            end
        end
        check("cont_first_irq_cycle", first, 11);
        check("cont_second_irq_cycle", second, 21);
        op(1'b1, 4'h1, 32'h8);
        idle(2);
        check("cont_irq_off", {31'd0, bus.irq}, 32'd0);

        // one-shot on ch1
        do_reset();
        op(1'b1, 4'h6, 32'd4);
        op(1'b1, 4'h5, 32'h4);
        op(1'b0, 4'h4, 32'd0);
        @(negedge clk);
        check("oneshot_running", bus.readdata, 32'h2);
        idle(8);
        op(1'b0, 4'h4, 32'd0);
        @(negedge clk);
        check("oneshot_status", bus.readdata, 32'h1);
        op(1'b1, 4'h7, 32'd0);
        op(1'b0, 4'h7, 32'd0);
        @(negedge clk);
        check("oneshot_counter", bus.readdata, 32'd4);
        check("oneshot_irq", {31'd0, bus.irq}, 32'd0);

        // status write colliding with a timeout, START beating STOP, period write stopping
        do_reset();
        op(1'b1, 4'h2, 32'd4);
        op(1'b1, 4'h1, 32'h6);
        idle(4);
        op(1'b1, 4'h0, 32'd0);
        op(1'b0, 4'h0, 32'd0);
        @(negedge clk);
        check("clear_vs_timeout", bus.readdata, 32'h3);
        op(1'b1, 4'h5, 32'h8);
        op(1'b1, 4'h5, 32'hC);
        op(1'b0, 4'h4, 32'd0);
        @(negedge clk);
        check("start_wins", bus.readdata, 32'h2);
        op(1'b1, 4'h6, 32'd3);
        op(1'b0, 4'h4, 32'd0);
        @(negedge clk);
        check("period_write_stops", bus.readdata, 32'h0);

        // snapshot at counter 3, then writes to absent channel 3
        do_reset();
        op(1'b1, 4'h2, 32'd10);
        op(1'b1, 4'h1, 32'h6);
        idle(7);
        op(1'b1, 4'h3, 32'hFFFF);
        op(1'b0, 4'h3, 32'd0);
        @(negedge clk);
        check("snapshot_at_3", bus.readdata, 32'd3);
        op(1'b1, 4'hE, 32'd7);
        op(1'b1, 4'hD, 32'h7);
        op(1'b1, 4'hC, 32'd0);
        op(1'b1, 4'hF, 32'd0);
        op(1'b0, 4'hE, 32'd0);
        @(negedge clk);
        check("ch3_reads_zero", bus.readdata, 32'd0);
        op(1'b0, 4'h2, 32'd0);
        @(negedge clk);
        check("ch0_period_kept", bus.readdata, 32'd10);
        op(1'b0, 4'h3, 32'd0);
        @(negedge clk);
        check("ch0_snapshot_kept", bus.readdata, 32'd3);
        op(1'b0, 4'h6, 32'd0);
        @(negedge clk);
        check("ch1_period_kept", bus.readdata, 32'd49999);
        op(1'b0, 4'h4, 32'd0);
        @(negedge clk);
        check("ch1_status_kept", bus.readdata, 32'd0);

        // period 0: timeout every cycle, TO survives a clear
        do_reset();
        op(1'b1, 4'h2, 32'd0);
        op(1'b1, 4'h1, 32'h7);
        idle(3);
        op(1'b1, 4'h0, 32'd0);
        op(1'b0, 4'h0, 32'd0);
        @(negedge clk);
        check("period0_status", bus.readdata, 32'h3);
        check("period0_irq", {31'd0, bus.irq}, 32'd1);

        // randomized traffic against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned p;
            logic [1:0]  ch;
            logic [1:0]  rg;
            logic [31:0] d;
            logic        cs;
            logic        wn;
            check("rnd_readdata", bus.readdata, m_rd);
            check("rnd_irq", {31'd0, bus.irq}, {31'd0, m_irq()});
            p  = $urandom_range(0, 99);
            ch = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            rg = 2'($urandom_range(0, 3));
            case (rg)
                2'd2:    d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
                2'd1:    d = $urandom & 32'h1F;
                default: d = $urandom;
            endcase
            if (p < 25)      begin cs = 1'b1; wn = 1'b0; end
            else if (p < 30) begin cs = 1'b1; wn = 1'b1; end
            else if (p < 33) begin cs = 1'b0; wn = 1'b0; end
            else             begin cs = 1'b0; wn = 1'b1; end
            drive_raw(cs, wn, {ch, rg}, d);
            model_edge(cs, wn, {ch, rg}, d);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nios_system_tec2_multi_timer.md
NIOS_SYSTEM_TEC2_MULTI_TIMER -- requirements
Module: nios_system_tec2_multi_timer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent timer channels, legal range 1..4.
REQ-002 Parameter CNT_W, default 32: counter and period width, legal range 8..32.
REQ-003 Parameter RELOAD_DEFAULT, default 49999: reset value of every period register and counter.
REQ-004 clk  input  1  single clock; all logic is rising-edge clocked.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  4  word address; [3:2] selects the channel, [1:0] selects the register.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 irq  output  1  OR of all per-channel interrupts.

Function
REQ-012 Per-channel register map SHALL be: 0 status {RUN[1], TO[0]}; 1 control {STOP[3], START[2], CONT[1], ITO[0]}; 2 period[CNT_W-1:0]; 3 snapshot.
REQ-013 Reads SHALL return the selected register in readdata one cycle after address is presented, with unused bits reading 0; channels >= NUM_CH SHALL read 0 and ignore writes.
REQ-014 A running counter SHALL decrement by 1 per cycle; when it is 0 it SHALL reload the period value on the next cycle, giving a timeout every period+1 cycles.
REQ-015 TO SHALL set on the cycle after the counter first becomes 0, detected as a rising edge against the registered previous zero flag.
REQ-016 A status write SHALL clear TO; if a timeout event occurs in the same cycle, TO SHALL end set.
REQ-017 A control write SHALL store bits [1:0]; START=1 SHALL set RUN; STOP=1 SHALL clear RUN; if both are 1, START SHALL win.
REQ-018 When CONT=0, RUN SHALL clear on the cycle after the counter reaches 0 (one-shot); when CONT=1, RUN SHALL stay set.
REQ-019 A period write SHALL truncate writedata to CNT_W bits, force a counter reload on the next cycle and clear RUN on that cycle, unless START is written in that same cycle.
REQ-020 A snapshot write (any data) SHALL copy the live counter into snapshot on the next edge.
REQ-021 Per-channel irq SHALL be TO AND ITO; irq SHALL be combinational from registers, with no bus dependency.
REQ-022 A period of 0 SHALL give a timeout on every cycle while running, with TO staying set.

Reset
REQ-023 On reset: counter = period = RELOAD_DEFAULT[CNT_W-1:0]; RUN, TO, control and snapshot = 0; readdata = 0; irq = 0.
REQ-024 Reset SHALL take priority over every bus access in the same cycle.

Configuration
REQ-025 Macro MULTI_TIMER_CASCADE_EN: when defined, control bit 4 (CAS) SHALL exist on channels 1..NUM_CH-1; with CAS=1 the channel SHALL decrement only on the cycle of the lower channel's timeout event, not on every clk.
REQ-026 Without MULTI_TIMER_CASCADE_EN, bit 4 SHALL read 0 and every channel SHALL count clk independently.

Verification
REQ-027 Reset, then read ch0 period -> readdata = 49999 one cycle later; ch1 status = 0; irq = 0.
REQ-028 ch0: period = 9, control = 0x7 (START, CONT, ITO) -> irq rises 10 cycles after the reload, status write clears it, irq recurs every 10 cycles.
REQ-029 ch1: period = 4, control = 0x4 (one-shot) -> TO set and RUN = 0 after one expiry, with the counter holding the reloaded value 4.
REQ-030 Status write in the same cycle as a timeout event -> TO = 1; control = 0xC -> RUN = 1.
REQ-031 Counter at 3, snapshot write -> snapshot reads 3 (or the value captured on the write edge); writing ch3 with NUM_CH = 2 -> no state change.
REQ-032 With MULTI_TIMER_CASCADE_EN: ch0 period = 1 continuous, ch1 period = 2 with CAS = 1 -> ch1 TO every 6 clk cycles.
